// File: rtl/frame_decoder.sv
// Framed byte-stream decoder: SYNC, CTRL, LEN, then LEN samples routed to a channel.
// ACK/NACK replies on the tx side, inter-byte timeout and a saturating error counter.
module frame_decoder #(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD = 8'hFF,
    parameter int                N_CH      = 4,
    parameter int                TIMEOUT   = 1024,
    parameter logic [DATA_W-1:0] NACK_WORD = 8'h15,
    localparam int               CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int               TO_W      = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_rx,
    input  logic              rx,
    output logic [DATA_W-1:0] data_tx,
    output logic              tx,
    output logic [DATA_W-1:0] sample,
    output logic              new_sample,
    output logic [CH_W-1:0]   sample_ch,
    output logic              frame_done,
    output logic              frame_err,
    output logic [15:0]       err_count,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CTRL = 2'd1;
    localparam logic [1:0] S_LEN  = 2'd2;
    localparam logic [1:0] S_RECV = 2'd3;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    logic [1:0]        state, state_nxt;
    logic [DATA_W-1:0] ctrl_q;
    logic [DATA_W-1:0] remaining;
    logic [TO_W-1:0]   to_cnt;
    logic              hdr_ok;
    logic              timed_out;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The whole CTRL byte is range-checked so stray high bits cannot alias onto a valid channel.
    assign hdr_ok    = (data_rx != '0) && (32'(ctrl_q) < N_CH);
    assign timed_out = !rx && (to_cnt == TO_LIM);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (rx && data_rx == SYNC_WORD) state_nxt = S_CTRL;
            S_CTRL: if (rx) state_nxt = S_LEN;
                    else if (timed_out) state_nxt = S_IDLE;
            S_LEN:  if (rx) state_nxt = hdr_ok ? S_RECV : S_IDLE;
                    else if (timed_out) state_nxt = S_IDLE;
            S_RECV: if (rx && remaining == DATA_W'(1)) state_nxt = S_IDLE;
                    else if (timed_out) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ctrl_q     <= '0;
            remaining  <= '0;
            to_cnt     <= '0;
            err_count  <= '0;
            data_tx    <= '0;
            tx         <= 1'b0;
            sample     <= '0;
            new_sample <= 1'b0;
            sample_ch  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != S_IDLE);
            tx         <= 1'b0;
            new_sample <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (state == S_IDLE || rx) to_cnt <= '0;
            else if (timed_out)        to_cnt <= '0;
            else                       to_cnt <= to_cnt + 1'b1;

            if (rx) begin
                case (state)
                    S_CTRL: ctrl_q <= data_rx;
                    S_LEN: begin
                        tx <= 1'b1;
                        if (hdr_ok) begin
                            remaining <= data_rx;
                            data_tx   <= ctrl_q;
                        end else begin
                            data_tx   <= NACK_WORD;
                            frame_err <= 1'b1;
                            err_count <= sat_inc(err_count);
                        end
                    end
                    S_RECV: begin
                        new_sample <= 1'b1;
                        sample     <= data_rx;
                        sample_ch  <= ctrl_q[CH_W-1:0];
                        remaining  <= remaining - 1'b1;
                        frame_done <= (remaining == DATA_W'(1));
                    end
                    default: ;
                endcase
            end else if (timed_out && state != S_IDLE) begin
                frame_err <= 1'b1;
                err_count <= sat_inc(err_count);
            end
        end
    end

endmodule
